// File: rtl/ads_bus_pkg.sv
// ads_bus_pkg
// Shared definitions for the serial slave-port front end: the slave FSM state
// encoding, the frame-level bit constants and a small elaboration-time helper.
// No ports (package).
package ads_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_MODE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_MEM,
    ST_ACK,
    ST_TX_START,
    ST_TX_DATA
  } slave_state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;
  localparam int   ACK_LEN    = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// slave_mem
// Single-port synchronous RAM, DATA_W x 2**ADDR_W, one-cycle read latency.
// Contents are never reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable (writes wdata_i to addr_i at the clock edge)
//   re_i     in   read enable (rdata_o valid the cycle after)
//   addr_i   in   word address
//   wdata_i  in   write data
//   rdata_o  out  registered read data
module slave_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/slave_port.sv
// slave_port
// Serial bus-side front end for one slave. Deserialises LSB-first write/read
// frames from rx, executes them on a local synchronous memory and serialises
// either a one-cycle write acknowledge or the read data back on tx.
// Frame: start(1), mode(1=write/0=read), ADDR_W address bits, [DATA_W data bits].
// Ports:
//   clk    in   bus clock
//   rstn   in   synchronous active-low reset (memory contents are kept)
//   rx     in   serial frame from the address decoder
//   tx     out  registered serial response
//   busy   in   slave-side stall; blocks frame start and the memory step
//   ready  out  high only in IDLE while busy is low
module slave_port
  import ads_bus_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx,
  input  logic busy,
  output logic ready
);

  localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);

  slave_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] txsh_q, txsh_d;
  logic              tx_q, tx_d;

  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // The write strobe is gated by rstn so a reset landing on the MEM cycle
  // suppresses the write rather than racing it.
  slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we & rstn),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (mem_rdata)
  );

  // tx_d describes the output for the state being entered, so the registered
  // tx lines up with the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    data_d  = data_q;
    txsh_d  = txsh_q;
    tx_d    = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((rx == START_BIT) && !busy) begin
          state_d = ST_RX_MODE;
        end
      end

      ST_RX_MODE: begin
        mode_d  = rx;
        cnt_d   = '0;
        state_d = ST_RX_ADDR;
      end

      // LSB-first: shift in at the top so the first bit ends at bit 0.
      ST_RX_ADDR: begin
        addr_d = {rx, addr_q[ADDR_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          cnt_d   = '0;
          state_d = (mode_q == MODE_WRITE) ? ST_RX_DATA : ST_MEM;
        end
      end

      ST_RX_DATA: begin
        data_d = {rx, data_q[DATA_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end
      end

      ST_MEM: begin
        if (!busy) begin
          tx_d  = 1'b1;
          cnt_d = '0;
          if (mode_q == MODE_WRITE) begin
            mem_we  = 1'b1;
            state_d = ST_ACK;
          end else begin
            mem_re  = 1'b1;
            state_d = ST_TX_START;
          end
        end
      end

      ST_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ACK_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tx_d = 1'b1;
        end
      end

      // Read data arrives this cycle; bit 0 goes straight out, the rest is
      // parked in the shifter.
      ST_TX_START: begin
        tx_d    = mem_rdata[0];
        txsh_d  = {1'b0, mem_rdata[DATA_W-1:1]};
        cnt_d   = '0;
        state_d = ST_TX_DATA;
      end

      ST_TX_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tx_d   = txsh_q[0];
          txsh_d = {1'b0, txsh_q[DATA_W-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      data_q  <= '0;
      txsh_q  <= '0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      txsh_q  <= txsh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx    = tx_q;
  assign ready = (state_q == ST_IDLE) && !busy;

endmodule

// File: tb/tb_slave_port.sv
module tb_slave_port;

  logic clk;
  logic rstn;
  logic rx;
  logic tx;
  logic busy;
  logic ready;

  int total;
  int bad;

  slave_port #(
    .ADDR_W (12),
    .DATA_W (8)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .tx    (tx),
    .busy  (busy),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  data;  // write data, or expected read data
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a frame starting at the current cycle (cycle 0) and records tx and
  // ready in every cycle. busy is high for cycles bfrom..bto inclusive.
  task automatic run(input logic [31:0] bits, input int nbits, input int ncyc,
                     input int bfrom, input int bto,
                     output logic [63:0] trace, output logic [63:0] rdy);
    trace = '0;
    rdy   = '0;
    for (int c = 0; c < ncyc; c++) begin
      rx   = (c < nbits) ? bits[c] : 1'b0;
      busy = (c >= bfrom) && (c <= bto);
      #1;
      trace[c] = tx;
      rdy[c]   = ready;
      @(posedge clk);
      #1;
    end
    rx   = 1'b0;
    busy = 1'b0;
  endtask

  function automatic logic [31:0] wframe(input logic [11:0] a, input logic [7:0] d);
    return {10'd0, d, a, 1'b1, 1'b1};
  endfunction

  function automatic logic [31:0] rframe(input logic [11:0] a);
    return {18'd0, a, 1'b0, 1'b1};
  endfunction

  function automatic logic [63:0] wtrace_exp();
    return 64'd1 << 23;
  endfunction

  function automatic logic [63:0] rtrace_exp(input logic [7:0] d);
    return (64'(d) << 16) | (64'd1 << 15);
  endfunction

  task automatic do_write(input string name, input logic [11:0] a, input logic [7:0] d);
    logic [63:0] tr, rd;
    run(wframe(a, d), 22, 26, 100, 0, tr, rd);
    chk({name, "_ack"}, tr & 64'h3FF_FFFF, wtrace_exp());
  endtask

  task automatic do_read(input string name, input logic [11:0] a, input logic [7:0] d);
    logic [63:0] tr, rd;
    run(rframe(a), 14, 26, 100, 0, tr, rd);
    chk({name, "_tx"}, tr & 64'h3FF_FFFF, rtrace_exp(d));
  endtask

  initial begin
    vec_t        vecs[9];
    logic [63:0] tr, rd;

    total = 0;
    bad   = 0;

    vecs[0] = '{1'b1, 12'h123, 8'hA5};
    vecs[1] = '{1'b0, 12'h123, 8'hA5};
    vecs[2] = '{1'b1, 12'h010, 8'h3C};
    vecs[3] = '{1'b0, 12'h010, 8'h3C};
    vecs[4] = '{1'b1, 12'h7FF, 8'h5A};
    vecs[5] = '{1'b0, 12'h7FF, 8'h5A};
    vecs[6] = '{1'b1, 12'h123, 8'hC3};
    vecs[7] = '{1'b0, 12'h123, 8'hC3};
    vecs[8] = '{1'b0, 12'h010, 8'h3C};

    rstn = 1'b0;
    rx   = 1'b0;
    busy = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_tx", 64'(tx), 64'd0);

    run(32'd0, 0, 10, 100, 0, tr, rd);
    chk("idle_rx0_tx", tr & 64'h3FF, 64'd0);

    // Table-driven frames: full tx trace plus ready before/during/after.
    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].wr) begin
        run(wframe(vecs[i].addr, vecs[i].data), 22, 26, 100, 0, tr, rd);
        chk({nm, "_wr_tx"}, tr & 64'h3FF_FFFF, wtrace_exp());
        chk({nm, "_wr_rdy"}, {62'd0, rd[24], rd[22]}, 64'b10);
      end else begin
        run(rframe(vecs[i].addr), 14, 26, 100, 0, tr, rd);
        chk({nm, "_rd_tx"}, tr & 64'h3FF_FFFF, rtrace_exp(vecs[i].data));
        chk({nm, "_rd_rdy"}, {62'd0, rd[24], rd[14]}, 64'b10);
      end
    end

    // busy rises mid-reception and holds MEM until cycle 40; ack at 41.
    run(wframe(12'h200, 8'h96), 22, 44, 5, 39, tr, rd);
    chk("busy_wr_tx", tr & 64'hFFF_FFFF_FFFF, 64'd1 << 41);
    chk("busy_wr_mem_rdy", 64'(rd[30]), 64'd0);
    chk("busy_wr_idle_rdy", 64'(rd[43]), 64'd1);
    do_read("busy_wr_readback", 12'h200, 8'h96);

    // busy toggling during the read response has no effect.
    run(rframe(12'h7FF), 14, 26, 16, 30, tr, rd);
    chk("busy_during_tx", tr & 64'h3FF_FFFF, rtrace_exp(8'h5A));

    // busy in IDLE: start bit ignored, nothing returned, memory untouched.
    run(wframe(12'h123, 8'hFF), 22, 26, 0, 100, tr, rd);
    chk("busy_idle_rdy", 64'(rd[0]), 64'd0);
    chk("busy_idle_tx", tr & 64'h3FF_FFFF, 64'd0);
    do_read("busy_idle_readback", 12'h123, 8'hC3);

    // Reset at cycle 8 of a write to 0x010.
    run(wframe(12'h010, 8'h77), 22, 8, 100, 0, tr, rd);
    rstn = 1'b0;
    rx   = 1'b1;
    step();
    rstn = 1'b1;
    rx   = 1'b0;
    #1;
    chk("rst_mid_tx", 64'(tx), 64'd0);
    chk("rst_mid_rdy", 64'(ready), 64'd1);
    do_read("rst_mid_readback", 12'h010, 8'h3C);

    // Reset on the MEM cycle of a write: the write must not land.
    run(wframe(12'h010, 8'h99), 22, 22, 100, 0, tr, rd);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    chk("rst_mem_tx", 64'(tx), 64'd0);
    do_read("rst_mem_readback", 12'h010, 8'h3C);

    // Back-to-back: second start in the first IDLE cycle (cycle 24).
    run(wframe(12'h000, 8'h11), 22, 24, 100, 0, tr, rd);
    chk("b2b_first_tx", tr & 64'hFF_FFFF, 64'd1 << 23);
    do_write("b2b_second", 12'hFFF, 8'hEE);
    do_read("b2b_rd0", 12'h000, 8'h11);
    do_read("b2b_rdfff", 12'hFFF, 8'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
